// File: rtl/hamming_stream_corrector_pkg.sv
// Elaboration-time helpers for Hamming bit placement.
// Shared by the block corrector and the stream wrapper.
package hamming_stream_corrector_pkg;

  function automatic logic is_pow2(input int p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  // Bit index of the k-th data bit in a block.
  function automatic int data_idx(input int k);
    int n;
    n = 0;
    for (int p = 1; p < 4096; p++) begin
      if (!is_pow2(p)) begin
        if (n == k) return p - 1;
        n++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/hamming.svh
// Shared Hamming width macros and position convention.
// Position p (1-based) lives at bit index p-1; parity at powers of two.
`ifndef HAMMING_SVH
`define HAMMING_SVH

`define HAMMING_PARITY_WIDTH(N) ($clog2((N) + 1))
`define HAMMING_DATA_WIDTH(N) ((N) - `HAMMING_PARITY_WIDTH(N))
`define HAMMING_POS(I) ((I) + 1)

`endif

// File: rtl/hamming_block_corrector.sv
// Combinational syndrome, single-bit fix and data extraction.
// Syndromes beyond the block are flagged, not fixed.
`include "hamming.svh"

module hamming_block_corrector
  import hamming_stream_corrector_pkg::*;
#(
  parameter int BLOCK_WIDTH = 15,
  localparam int PARITY_WIDTH =
    `HAMMING_PARITY_WIDTH(BLOCK_WIDTH),
  localparam int DATA_WIDTH =
    `HAMMING_DATA_WIDTH(BLOCK_WIDTH)
) (
  input  logic [BLOCK_WIDTH-1:0] i_block,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_corrected,
  output logic                   o_uncorrectable
);

  logic [PARITY_WIDTH-1:0] w_syn;
  logic                    w_hit;
  logic [BLOCK_WIDTH-1:0]  w_fixed;

  always_comb begin
    w_syn = '0;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      if (i_block[i])
        w_syn = w_syn ^ PARITY_WIDTH'(`HAMMING_POS(i));
    end
  end

  always_comb begin
    w_hit = (w_syn != '0) &&
            (int'(w_syn) <= BLOCK_WIDTH);
    w_fixed = i_block;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      if (w_hit &&
          w_syn == PARITY_WIDTH'(`HAMMING_POS(i)))
        w_fixed[i] = ~i_block[i];
    end
  end

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_ext
    assign o_data[k] = w_fixed[data_idx(k)];
  end

  assign o_corrected     = w_hit;
  assign o_uncorrectable = (w_syn != '0) && !w_hit;

endmodule

// File: rtl/hamming_stream_corrector.sv
// Registered Hamming corrector with valid/ready stream ports.
// Error counter enabled by HAMMING_STREAM_CORRECTOR_COUNTER_EN.
`include "hamming.svh"

module hamming_stream_corrector
  import hamming_stream_corrector_pkg::*;
#(
  parameter int BLOCK_WIDTH   = 15,
  parameter int COUNTER_WIDTH = 16,
  localparam int DATA_WIDTH =
    `HAMMING_DATA_WIDTH(BLOCK_WIDTH),
  localparam int PARITY_WIDTH =
    `HAMMING_PARITY_WIDTH(BLOCK_WIDTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     upstream_valid,
  output logic                     upstream_ready,
  input  logic [BLOCK_WIDTH-1:0]   upstream_block,
  output logic                     downstream_valid,
  input  logic                     downstream_ready,
  output logic [DATA_WIDTH-1:0]    downstream_data,
  output logic                     downstream_corrected,
  output logic                     downstream_uncorrectable,
  output logic [COUNTER_WIDTH-1:0] error_count,
  input  logic                     error_count_clear
);

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_corr;
  logic                  w_unc;
  logic                  w_accept;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_corr;
  logic                  r_unc;

  hamming_block_corrector #(
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_blk (
    .i_block        (upstream_block),
    .o_data         (w_data),
    .o_corrected    (w_corr),
    .o_uncorrectable(w_unc)
  );

  assign upstream_ready = !r_valid || downstream_ready;
  assign w_accept = upstream_valid && upstream_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_corr  <= 1'b0;
      r_unc   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_corr  <= w_corr;
      r_unc   <= w_unc;
    end else if (downstream_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign downstream_valid         = r_valid;
  assign downstream_data          = r_data;
  assign downstream_corrected     = r_corr;
  assign downstream_uncorrectable = r_unc;

`ifdef HAMMING_STREAM_CORRECTOR_COUNTER_EN
  logic                     w_event;
  logic [COUNTER_WIDTH-1:0] r_count;

  assign w_event = w_accept && (w_corr || w_unc);

  // Clear wins over history but still counts a same-cycle event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_count <= '0;
    else if (error_count_clear)
      r_count <= COUNTER_WIDTH'(w_event);
    else if (w_event && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign error_count = r_count;
`else
  logic w_unused;
  assign w_unused    = error_count_clear;
  assign error_count = '0;
`endif

endmodule

// File: doc/hamming_stream_corrector.md
HAMMING_STREAM_CORRECTOR -- requirements
Module: hamming_stream_corrector

Interface
REQ-001 SHALL have parameter BLOCK_WIDTH, default 15, total Hamming block width in bits (parity at power-of-two positions, position p = bit index p-1).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 16, width of the error event counter.
REQ-003 SHALL derive DATA_WIDTH and PARITY_WIDTH from BLOCK_WIDTH using the shared Hamming width macros.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 upstream_valid  input  1  upstream block valid.
REQ-007 upstream_ready  output  1  block accepted when valid and ready.
REQ-008 upstream_block  input  BLOCK_WIDTH  received Hamming block.
REQ-009 downstream_valid  output  1  output word valid.
REQ-010 downstream_ready  input  1  downstream accepts.
REQ-011 downstream_data  output  DATA_WIDTH  corrected data.
REQ-012 downstream_corrected  output  1  single-bit error was corrected in this word.
REQ-013 downstream_uncorrectable  output  1  syndrome pointed outside the block; data passed uncorrected.
REQ-014 error_count  output  COUNTER_WIDTH  error event count (only with counter macro).
REQ-015 error_count_clear  input  1  synchronous counter clear (only with counter macro).

Function
REQ-016 SHALL compute syndrome S = XOR of positions of all set bits in upstream_block (equivalently received code XOR re-encoded code).
REQ-017 S == 0: data unchanged, corrected=0, uncorrectable=0.
REQ-018 1 <= S <= BLOCK_WIDTH: bit index S-1 inverted before extraction, corrected=1.
REQ-019 S > BLOCK_WIDTH (shortened codes only): data extracted unmodified, uncorrectable=1, corrected=0.
REQ-020 Error in a parity position SHALL still set corrected=1, with data unaffected.
REQ-021 Single output register stage; latency exactly 1 cycle from accepting handshake to downstream_valid.
REQ-022 upstream_ready = !downstream_valid || downstream_ready (combinational, no upstream_valid dependency).
REQ-023 Output register loads on accept; downstream_valid clears when downstream handshakes and no new accept occurs in the same cycle.
REQ-024 Simultaneous downstream handshake and upstream accept SHALL replace the word with no bubble (full throughput).
REQ-025 downstream_data/corrected/uncorrectable SHALL hold stable while downstream_valid=1 and downstream_ready=0.
REQ-026 Double-bit errors are not detectable by this code; block miscorrects silently (documented limitation).

Reset
REQ-027 On resetn low: downstream_valid=0, downstream_data=0, corrected=0, uncorrectable=0, error_count=0, immediately and asynchronously.
REQ-028 Reset mid-transfer SHALL discard the held word; no word emitted after reset release until a new accept.

Configuration
REQ-029 Macro HAMMING_STREAM_CORRECTOR_COUNTER_EN defined: error_count increments by 1 on each accepted block with S != 0, saturates at all-ones, never wraps.
REQ-030 Clear and a counted event in the same cycle: error_count = 1; clear alone: 0.
REQ-031 Macro undefined: no counter flops; error_count driven 0, error_count_clear ignored.

Structure
REQ-032 Width derivation macros and the syndrome/position convention SHALL live in the shared hamming.svh header; no local redefinition.
REQ-033 Combinational syndrome, bit-flip and extraction SHALL be a sub-module hamming_block_corrector (block in; data, corrected, uncorrectable out); this module adds handshake, register and counter.

Verification
REQ-034 BLOCK_WIDTH=15, block 0x0000, valid held, ready=1 -> data 0x000, corrected=0, next cycle valid=1, one word per cycle.
REQ-035 BLOCK_WIDTH=15, encoded data 0x000 with bit 4 flipped (0x0010, S=5) -> data 0x000, corrected=1, error_count 0->1.
REQ-036 BLOCK_WIDTH=12, block with bits 0 and 11 set (S=1^12=13) -> uncorrectable=1, corrected=0, data unmodified.
REQ-037 downstream_ready=0 for 5 cycles after a word -> upstream_ready=0, output stable; ready=1 -> word consumed, next accepted same cycle.
REQ-038 Counter at all-ones plus error -> stays all-ones; clear with error same cycle -> 1; resetn pulse mid-stall -> valid=0, count=0.
